// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  uart_pkg : shared constants, FSM state type and baud divisor helper
//  Rev 1.0
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // Nearest-integer clocks per bit.
    function automatic int calc_div(input longint clk_freq, input longint baud);
        return int'((clk_freq + (baud / 2)) / baud);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  uart_baud_gen : free-running bit-period counter, cleared while run is low
//  Rev 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic hw_clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    localparam int            c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == c_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = run && (cnt_q == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  uart_tx_fifo : parametrised UART transmitter with a small valid/ready FIFO
//  Rev 1.0
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          hw_clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uarttx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              DIV         = calc_div(CLK_FREQ, BAUD);
    localparam int              c_aw        = $clog2(FIFO_DEPTH);
    localparam logic [3:0]      c_data_last = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_stop_last = 4'(STOP_BITS - 1);
    localparam logic            c_odd       = (PARITY == PARITY_ODD);
    localparam logic            c_has_par   = (PARITY != PARITY_NONE);

    generate
        if (DIV < 4) begin : g_bad_div
            $error("uart_tx_fifo: CLK_FREQ/BAUD gives DIV=%0d, must be >= 4", DIV);
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS=%0d outside 5..8", DATA_BITS);
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY=%0d not in {0,1,2}", PARITY);
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS=%0d not in {1,2}", STOP_BITS);
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH=%0d must be a power of two >= 2", FIFO_DEPTH);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [c_aw:0]        wr_ptr_q;
    logic [c_aw:0]        rd_ptr_q;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    // Extra pointer MSB separates full from empty when the address bits match.
    assign w_empty    = (wr_ptr_q == rd_ptr_q);
    assign w_full     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                        (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign tx_ready   = !w_full;
    assign w_push     = tx_valid && !w_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign w_head     = mem_q[rd_ptr_q[c_aw-1:0]];

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge hw_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= tx_data;
        end
    end

    // ------------------------------------------------------------------
    // Bit timing
    // ------------------------------------------------------------------
    tx_state_e state_q;
    logic      w_run;
    logic      w_tick;

    assign w_run = (state_q != ST_IDLE);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .hw_clk   (hw_clk),
        .rst      (rst),
        .run      (w_run),
        .bit_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic [3:0]           bitcnt_q;
    logic                 uarttx_q;
    logic                 line_busy_q;
    logic                 w_last_stop;

    assign w_last_stop = (state_q == ST_STOP) && w_tick && (bitcnt_q == c_stop_last);
    // Popping at the final stop tick chains frames with no idle gap.
    assign w_pop       = !w_empty && ((state_q == ST_IDLE) || w_last_stop);

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            par_q       <= 1'b0;
            bitcnt_q    <= '0;
            uarttx_q    <= 1'b1;
            line_busy_q <= 1'b0;
        end else begin
            // The line lags the state by one clock; line_busy_q covers that lag.
            line_busy_q <= (state_q != ST_IDLE);
            case (state_q)
                ST_START: uarttx_q <= 1'b0;
                ST_DATA:  uarttx_q <= shift_q[0];
                ST_PAR:   uarttx_q <= par_q;
                default:  uarttx_q <= 1'b1;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (w_pop) begin
                        shift_q  <= w_head;
                        par_q    <= (^w_head) ^ c_odd;
                        bitcnt_q <= '0;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        bitcnt_q <= '0;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bitcnt_q == c_data_last) begin
                            bitcnt_q <= '0;
                            state_q  <= c_has_par ? ST_PAR : ST_STOP;
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_tick) begin
                        bitcnt_q <= '0;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (bitcnt_q == c_stop_last) begin
                            bitcnt_q <= '0;
                            if (w_pop) begin
                                shift_q <= w_head;
                                par_q   <= (^w_head) ^ c_odd;
                                state_q <= ST_START;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    bitcnt_q <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign uarttx = uarttx_q;
    assign busy   = (state_q != ST_IDLE) || !w_empty || line_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  tb_uart_tx_fifo : scoreboard bench, three frame formats driven in parallel
//  Rev 1.0
// ============================================================================
module tb_uart_tx_fifo;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit done [NCFG];

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // g0: 8N1, g1: 7 data + odd parity + 2 stop, g2: default clocking, 8E1, depth 2
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int DB     = (g == 1) ? 7 : 8;
        localparam int PA     = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int SB     = (g == 1) ? 2 : 1;
        localparam int DEP    = (g == 2) ? 2 : 4;
        localparam int CF     = (g == 2) ? 12000000 : 1000000;
        localparam int BR     = (g == 2) ? 9600 : 100000;
        localparam int DV     = (CF + BR / 2) / BR;
        localparam int NB     = 1 + DB + ((PA != 0) ? 1 : 0) + SB;
        localparam int FL     = NB * DV;
        localparam int NBURST = DEP + 2;
        localparam int NRAND  = (g == 2) ? 0 : 20;
        localparam logic [7:0] FIRST = (g == 0) ? 8'h44 : ((g == 1) ? 8'h7F : 8'h55);

        logic                    rst      = 1'b1;
        logic [DB-1:0]           tx_data  = '0;
        logic                    tx_valid = 1'b0;
        logic                    tx_ready;
        logic                    uarttx;
        logic                    busy;
        logic [$clog2(DEP):0]    fifo_count;
        logic                    mon_en   = 1'b1;
        logic [7:0]              exp_q [$];
        int                      starts [$];

        uart_tx_fifo #(
            .CLK_FREQ   (CF),
            .BAUD       (BR),
            .DATA_BITS  (DB),
            .PARITY     (PA),
            .STOP_BITS  (SB),
            .FIFO_DEPTH (DEP)
        ) u_dut (
            .hw_clk     (clk),
            .rst        (rst),
            .tx_data    (tx_data),
            .tx_valid   (tx_valid),
            .tx_ready   (tx_ready),
            .uarttx     (uarttx),
            .busy       (busy),
            .fifo_count (fifo_count)
        );

        // Line level of bit slot i of the frame carrying byte b.
        function automatic logic line_bit(input logic [7:0] b, input int i);
            logic [7:0] d;
            d = b & 8'((1 << DB) - 1);
            if (i == 0) return 1'b0;
            if (i <= DB) return d[i-1];
            if (PA != 0 && i == DB + 1) begin
                if (PA == 1) return logic'($countones(d) % 2);
                return logic'(1 - ($countones(d) % 2));
            end
            return 1'b1;
        endfunction

        task automatic push(input logic [7:0] b, output int acc);
            tx_data  = b[DB-1:0];
            tx_valid = 1'b1;
            acc      = -1;
            for (int t = 0; t < 4 * FL + 10; t++) begin
                @(negedge clk);
                if (tx_ready) begin
                    @(posedge clk);
                    #1;
                    acc = cyc;
                    if (mon_en) exp_q.push_back(b & 8'((1 << DB) - 1));
                    break;
                end
            end
            tx_valid = 1'b0;
            if (acc < 0) check($sformatf("g%0d push_timeout_0x%02h", g, b), 0, 1);
        endtask

        task automatic wait_idle(input string nm);
            int t;
            t = 0;
            while ((busy !== 1'b0 || exp_q.size() != 0) && t < (DEP + 3) * FL + 100) begin
                @(posedge clk);
                #1;
                t++;
            end
            check($sformatf("g%0d %s_drained_queue_left", g, nm), exp_q.size(), 0);
            check($sformatf("g%0d %s_busy_after_drain", g, nm), busy, 0);
        endtask

        initial begin : p_mon
            logic [7:0] b;
            int         errs;
            forever begin
                @(posedge clk);
                #1;
                if (mon_en && !rst && uarttx === 1'b0) begin
                    starts.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        check($sformatf("g%0d unexpected_frame_at_cycle_%0d", g, cyc), 1, 0);
                        for (int k = 0; k < FL && uarttx === 1'b0; k++) begin
                            @(posedge clk);
                            #1;
                        end
                    end else begin
                        b    = exp_q.pop_front();
                        errs = 0;
                        for (int i = 0; i < NB; i++) begin
                            for (int k = 0; k < DV; k++) begin
                                if (i != 0 || k != 0) begin
                                    @(posedge clk);
                                    #1;
                                end
                                if (uarttx !== line_bit(b, i)) errs++;
                            end
                        end
                        check($sformatf("g%0d frame_0x%02h_wrong_line_cycles", g, b), errs, 0);
                    end
                end
            end
        end

        initial begin : p_drv
            int acc, s0, bf, nst, maxc, badrdy, hi, t;
            bit bdone;

            repeat (3) @(posedge clk);
            #1;
            check($sformatf("g%0d reset_uarttx", g), uarttx, 1);
            check($sformatf("g%0d reset_busy", g), busy, 0);
            check($sformatf("g%0d reset_fifo_count", g), fifo_count, 0);
            check($sformatf("g%0d reset_tx_ready", g), tx_ready, 1);
            @(negedge clk) rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;

            // Single byte from idle: start-bit latency and whole-frame length.
            nst = starts.size();
            push(FIRST, acc);
            t = 0;
            while (starts.size() == nst && t < 10) begin
                @(posedge clk);
                #1;
                t++;
            end
            s0 = (starts.size() > nst) ? starts[nst] : -1000000;
            check($sformatf("g%0d start_latency_from_accept", g), s0 - acc, 2);
            bf = -1;
            for (int k = 0; k < FL + 20; k++) begin
                if (busy === 1'b0) begin
                    bf = cyc;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("g%0d busy_fall_cycles_after_start", g), bf - s0, FL);
            wait_idle("single");

            // Burst with tx_valid held: FIFO fills, last byte waits for a pop.
            nst    = starts.size();
            maxc   = 0;
            badrdy = 0;
            bdone  = 1'b0;
            fork
                begin
                    for (int i = 0; i < NBURST; i++) push(8'h41 + 8'(i), acc);
                    bdone = 1'b1;
                end
                begin
                    for (int k = 0; k < (NBURST + 2) * FL && !bdone; k++) begin
                        @(negedge clk);
                        if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
                        if ((int'(fifo_count) == DEP) == tx_ready) badrdy++;
                    end
                end
            join
            wait_idle("burst");
            check($sformatf("g%0d burst_max_fifo_count", g), maxc, DEP);
            check($sformatf("g%0d burst_ready_vs_full_errors", g), badrdy, 0);
            check($sformatf("g%0d burst_frames_seen", g), starts.size() - nst, NBURST);
            s0 = (starts.size() > nst) ? starts[nst] : -1000000;
            check($sformatf("g%0d burst_last_accept_after_first_frame", g), acc - s0, FL);
            for (int k = nst; k + 1 < starts.size(); k++) begin
                check($sformatf("g%0d burst_gap_frame_%0d", g, k - nst), starts[k+1] - starts[k], FL);
            end

            // Random bytes with random spacing, some back-to-back.
            for (int i = 0; i < NRAND; i++) begin
                push(8'($urandom_range(0, 255)), acc);
                repeat ((i % 3 == 0) ? $urandom_range(0, FL + 20) : $urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            wait_idle("random");

            // Reset mid-frame with bytes queued.
            mon_en = 1'b0;
            for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)), acc);
            t = 0;
            while (uarttx !== 1'b0 && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            repeat (37) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check($sformatf("g%0d midframe_reset_uarttx", g), uarttx, 1);
            check($sformatf("g%0d midframe_reset_fifo_count", g), fifo_count, 0);
            check($sformatf("g%0d midframe_reset_busy", g), busy, 0);
            repeat (3) @(posedge clk);
            @(negedge clk) rst = 1'b0;
            hi = 1;
            for (int k = 0; k < 3 * DV + 200; k++) begin
                @(posedge clk);
                #1;
                if (uarttx !== 1'b1 || busy !== 1'b0) hi = 0;
            end
            check($sformatf("g%0d no_activity_after_reset", g), hi, 1);
            mon_en = 1'b1;

            done[g] = 1'b1;
        end
    end

    initial begin : p_end
        for (int t = 0; t < 95000; t++) begin
            @(posedge clk);
            if (done[0] && done[1] && done[2]) break;
        end
        if (!(done[0] && done[1] && done[2])) begin
            check("watchdog_all_configs_finished", 0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
